taillight_ctrl: RTL and testbench

TAILLIGHT_CTRL -- requirements
Module: taillight_ctrl

---
 rtl/turn_pkg.sv | 76 +++++++
 rtl/step_prescaler.sv | 26 ++
 rtl/taillight_ctrl.sv | 83 ++++++++
 tb/tb_taillight_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// Shared mode encodings, sequence states and lamp patterns for the tail-light controller.
package turn_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'b00,
      MODE_RIGHT = 2'b01,
      MODE_LEFT  = 2'b10,
      MODE_HAZ   = 2'b11
   } mode_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_L1, ST_L2, ST_L3, ST_L4,
      ST_R1, ST_R2, ST_R3, ST_R4,
      ST_H1, ST_H2
   } seq_t;

   // Lamp bits 5..0: L_outer, L_middle, L_inner, R_inner, R_middle, R_outer.
   localparam logic [5:0] PAT_L1 = 6'b001000;
   localparam logic [5:0] PAT_L2 = 6'b011000;
   localparam logic [5:0] PAT_L3 = 6'b111000;
   localparam logic [5:0] PAT_L4 = 6'b000000;
   localparam logic [5:0] PAT_R1 = 6'b000100;
   localparam logic [5:0] PAT_R2 = 6'b000110;
   localparam logic [5:0] PAT_R3 = 6'b000111;
   localparam logic [5:0] PAT_R4 = 6'b000000;
   localparam logic [5:0] PAT_H1 = 6'b111111;
   localparam logic [5:0] PAT_H2 = 6'b000000;

   // Brake lights use whichever side is not signalling.
   localparam logic [5:0] BRK_IDLE  = 6'b111111;
   localparam logic [5:0] BRK_LEFT  = 6'b000111;
   localparam logic [5:0] BRK_RIGHT = 6'b111000;

   function automatic seq_t first_state(input mode_t m);
      case (m)
         MODE_LEFT:  return ST_L1;
         MODE_RIGHT: return ST_R1;
         MODE_HAZ:   return ST_H1;
         default:    return ST_IDLE;
      endcase
   endfunction

   function automatic seq_t next_seq(input seq_t s);
      case (s)
         ST_L1:   return ST_L2;
         ST_L2:   return ST_L3;
         ST_L3:   return ST_L4;
         ST_L4:   return ST_L1;
         ST_R1:   return ST_R2;
         ST_R2:   return ST_R3;
         ST_R3:   return ST_R4;
         ST_R4:   return ST_R1;
         ST_H1:   return ST_H2;
         ST_H2:   return ST_H1;
         default: return ST_IDLE;
      endcase
   endfunction

   function automatic logic [5:0] seq_lamp(input seq_t s);
      case (s)
         ST_L1:   return PAT_L1;
         ST_L2:   return PAT_L2;
         ST_L3:   return PAT_L3;
         ST_L4:   return PAT_L4;
         ST_R1:   return PAT_R1;
         ST_R2:   return PAT_R2;
         ST_R3:   return PAT_R3;
         ST_R4:   return PAT_R4;
         ST_H1:   return PAT_H1;
         ST_H2:   return PAT_H2;
         default: return 6'b000000;
      endcase
   endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running 0..DIV-1 step counter; TICK marks the last count, CLR restarts from 0.
module step_prescaler #(
   parameter int DIV = 4
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic CLR,
   output logic TICK
);

   localparam logic [7:0] LAST = 8'(DIV - 1);

   logic [7:0] cnt_q;

   assign TICK = (cnt_q == LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         cnt_q <= 8'd0;
      else if (CLR || TICK)
         cnt_q <= 8'd0;
      else
         cnt_q <= cnt_q + 8'd1;
   end

endmodule

// File: rtl/taillight_ctrl.sv
// Sequential tail-light controller: turn/hazard sequencing with brake overlay and registered lamps.
module taillight_ctrl
   import turn_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       LEFT,
   input  logic       RIGHT,
   input  logic       HAZ,
   input  logic       BRAKE,
   output logic [5:0] LAMP,
   output logic [1:0] MODE,
   output logic       STEP
);

   mode_t      req_mode, mode_q, mode_nxt;
   seq_t       state_q, state_nxt;
   logic [5:0] lamp_q, lamp_nxt;
   logic       step_q, step_nxt;
   logic       chg, tick;

   always_comb begin
      req_mode = MODE_IDLE;
      if (HAZ)
         req_mode = MODE_HAZ;
      else if (LEFT ^ RIGHT)
         req_mode = LEFT ? MODE_LEFT : MODE_RIGHT;
   end

   assign chg = (req_mode != mode_q);

   step_prescaler #(.DIV(DIV)) u_presc (
      .CLK   (CLK),
      .RST_N (RST_N),
      .CLR   (chg),
      .TICK  (tick)
   );

   // A mode change always wins over a coincident tick.
   always_comb begin
      mode_nxt  = mode_q;
      state_nxt = state_q;
      step_nxt  = 1'b0;
      if (chg) begin
         mode_nxt  = req_mode;
         state_nxt = first_state(req_mode);
      end else if (tick && (mode_q != MODE_IDLE)) begin
         state_nxt = next_seq(state_q);
         step_nxt  = 1'b1;
      end

      lamp_nxt = seq_lamp(state_nxt);
      if (BRAKE) begin
         case (mode_nxt)
            MODE_IDLE:  lamp_nxt = BRK_IDLE;
            MODE_LEFT:  lamp_nxt = lamp_nxt | BRK_LEFT;
            MODE_RIGHT: lamp_nxt = lamp_nxt | BRK_RIGHT;
            default:    lamp_nxt = seq_lamp(state_nxt);
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mode_q  <= MODE_IDLE;
         state_q <= ST_IDLE;
         lamp_q  <= 6'b000000;
         step_q  <= 1'b0;
      end else begin
         mode_q  <= mode_nxt;
         state_q <= state_nxt;
         lamp_q  <= lamp_nxt;
         step_q  <= step_nxt;
      end
   end

   assign LAMP = lamp_q;
   assign MODE = mode_q;
   assign STEP = step_q;

endmodule

// File: tb/tb_taillight_ctrl.sv
// Directed bench for taillight_ctrl with DIV=4 and hand-computed lamp/mode/step values.
module tb_taillight_ctrl;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       LEFT = 1'b0, RIGHT = 1'b0, HAZ = 1'b0, BRAKE = 1'b0;
   logic [5:0] LAMP;
   logic [1:0] MODE;
   logic       STEP;

   int n_tests = 0;
   int n_fail  = 0;

   taillight_ctrl #(.DIV(4)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .LEFT  (LEFT),
      .RIGHT (RIGHT),
      .HAZ   (HAZ),
      .BRAKE (BRAKE),
      .LAMP  (LAMP),
      .MODE  (MODE),
      .STEP  (STEP)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [5:0] lamp, input logic [1:0] mode,
                          input logic step);
      check({tag, ".lamp"}, LAMP, lamp);
      check({tag, ".mode"}, {4'b0, MODE}, {4'b0, mode});
      check({tag, ".step"}, {5'b0, STEP}, {5'b0, step});
   endtask

   logic [5:0] left_seq [4] = '{6'b011000, 6'b111000, 6'b000000, 6'b001000};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      #22;
      chk_out("reset", 6'b000000, 2'b00, 1'b0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      LEFT  = 1'b1;

      // Left sequence from idle
      cyc(1);
      chk_out("left_entry", 6'b001000, 2'b10, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(3);
         chk_out($sformatf("left_hold%0d", i), (i == 0) ? 6'b001000 : left_seq[i-1], 2'b10, 1'b0);
         cyc(1);
         chk_out($sformatf("left_step%0d", i), left_seq[i], 2'b10, 1'b1);
      end

      // Switch left->right at L3
      cyc(4);
      check("to_L2", LAMP, 6'b011000);
      cyc(4);
      check("to_L3", LAMP, 6'b111000);
      LEFT = 1'b0; RIGHT = 1'b1;
      cyc(1);
      chk_out("switch_right", 6'b000100, 2'b01, 1'b0);
      cyc(3);
      chk_out("right_hold", 6'b000100, 2'b01, 1'b0);
      cyc(1);
      chk_out("right_R2", 6'b000110, 2'b01, 1'b1);

      // Brake during R2, then release
      BRAKE = 1'b1;
      cyc(1);
      chk_out("brake_R2", 6'b111110, 2'b01, 1'b0);
      BRAKE = 1'b0;
      cyc(1);
      check("unbrake_R2", LAMP, 6'b000110);
      cyc(1);
      check("R2_still", LAMP, 6'b000110);
      cyc(1);
      chk_out("right_R3", 6'b000111, 2'b01, 1'b1);

      // Hazard overrides left and brake
      HAZ = 1'b1; LEFT = 1'b1; RIGHT = 1'b0; BRAKE = 1'b1;
      cyc(1);
      chk_out("haz_H1", 6'b111111, 2'b11, 1'b0);
      cyc(3);
      check("haz_hold", LAMP, 6'b111111);
      cyc(1);
      chk_out("haz_H2", 6'b000000, 2'b11, 1'b1);
      cyc(4);
      chk_out("haz_H1b", 6'b111111, 2'b11, 1'b1);
      HAZ = 1'b0;
      cyc(1);
      chk_out("haz_drop", 6'b001111, 2'b10, 1'b0);

      // Both turn requests -> idle
      RIGHT = 1'b1; BRAKE = 1'b0;
      cyc(1);
      chk_out("both_idle", 6'b000000, 2'b00, 1'b0);
      BRAKE = 1'b1;
      cyc(1);
      chk_out("idle_brake", 6'b111111, 2'b00, 1'b0);

      // Asynchronous reset mid-L2
      BRAKE = 1'b0; RIGHT = 1'b0;
      cyc(1);
      check("l1_again", LAMP, 6'b001000);
      cyc(4);
      check("l2_again", LAMP, 6'b011000);
      cyc(1);
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      chk_out("async_rst", 6'b000000, 2'b00, 1'b0);
      @(posedge CLK); #1;
      check("rst_held", LAMP, 6'b000000);
      RST_N = 1'b1;
      cyc(1);
      chk_out("post_rst", 6'b001000, 2'b10, 1'b0);

      // One-cycle request glitch is honoured
      LEFT = 1'b0; RIGHT = 1'b1;
      cyc(1);
      chk_out("glitch_r", 6'b000100, 2'b01, 1'b0);
      LEFT = 1'b1; RIGHT = 1'b0;
      cyc(1);
      chk_out("glitch_back", 6'b001000, 2'b10, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
